// File: rtl/pcpu_pkg.sv
// Shared pipeline-control definitions: register-address width, the
// "operand comes from the register file" selector value, and the
// multi-cycle-unit occupancy states.
package pcpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int FWD_SEL_RF = 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/inflight_slot.sv
// One entry of the in-flight writer table. Captures the instruction
// description presented on its inputs every cycle and reports whether
// the held writer supplies either ID source operand.
module inflight_slot #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_wreg,
    input  logic [REG_ADDR_W-1:0] in_dst,
    input  logic                  in_is_load,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic                  use_rs,
    input  logic                  use_rt,
    output logic                  valid,
    output logic                  wreg,
    output logic [REG_ADDR_W-1:0] dst,
    output logic                  is_load,
    output logic                  match_rs,
    output logic                  match_rt
);

    // A slot is a real producer only if it holds a valid, register-writing
    // instruction whose destination is not the hard-wired zero register.
    logic producer;

    // Slot contents advance every cycle; reset empties the slot at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            wreg    <= 1'b0;
            dst     <= '0;
            is_load <= 1'b0;
        end else begin
            valid   <= in_valid;
            wreg    <= in_wreg;
            dst     <= in_dst;
            is_load <= in_is_load;
        end
    end

    // Operand match against the instruction currently in ID.
    always_comb begin
        producer = valid & wreg & (dst != '0);
        match_rs = producer & use_rs & (dst == rs);
        match_rt = producer & use_rt & (dst == rt);
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding selects, load-use and
// multi-cycle-unit stalls, and branch flush for the ID stage.
//
// Handshake: the ID instruction is taken (accepted) on a rising edge
// when id_valid=1 and stall=0 on that cycle; while stall=1 the same
// instruction must be held in ID. flush is only raised for an accepted
// taken branch, so a stalled branch is re-evaluated the next cycle.
module hazard_unit #(
    parameter int REG_ADDR_W = pcpu_pkg::REG_ADDR_W,
    parameter int FWD_DEPTH  = 2,
    parameter int MDU_LAT    = 4,
    localparam int FWD_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  id_wreg,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_is_load,
    input  logic                  id_is_mdu,
    input  logic                  id_branch_taken,
    output logic [FWD_W-1:0]      fwda,
    output logic [FWD_W-1:0]      fwdb,
    output logic                  stall,
    output logic                  flush,
    output logic                  mdu_busy
);

    import pcpu_pkg::*;

    localparam int CNT_W = $clog2(MDU_LAT);

    // In-flight table, index 0 is the youngest slot (stage 1).
    logic [FWD_DEPTH-1:0]  s_valid;
    logic [FWD_DEPTH-1:0]  s_wreg;
    logic [REG_ADDR_W-1:0] s_dst [FWD_DEPTH];
    logic [FWD_DEPTH-1:0]  s_is_load;
    logic [FWD_DEPTH-1:0]  match_rs;
    logic [FWD_DEPTH-1:0]  match_rt;

    // Multi-cycle unit tracking; mdu_state is the observable FSM state.
    mdu_state_t       mdu_state;
    mdu_state_t       mdu_state_d;
    logic [CNT_W-1:0] mdu_cnt;
    logic [CNT_W-1:0] mdu_cnt_d;

    logic load_use;
    logic mdu_stall;
    logic accepted;

    // The oldest slot's contents fall off the end of the table.
    logic unused_tail;
    assign unused_tail = ^{s_valid[FWD_DEPTH-1], s_wreg[FWD_DEPTH-1],
                           s_dst[FWD_DEPTH-1], s_is_load[FWD_DEPTH-1]};

    for (genvar k = 0; k < FWD_DEPTH; k++) begin : g_slot
        logic                  in_valid;
        logic                  in_wreg;
        logic [REG_ADDR_W-1:0] in_dst;
        logic                  in_is_load;

        if (k == 0) begin : g_head
            // A stalled or empty ID stage enters the table as a bubble.
            assign in_valid   = accepted;
            assign in_wreg    = id_wreg;
            assign in_dst     = id_dst;
            assign in_is_load = id_is_load;
        end else begin : g_body
            assign in_valid   = s_valid[k-1];
            assign in_wreg    = s_wreg[k-1];
            assign in_dst     = s_dst[k-1];
            assign in_is_load = s_is_load[k-1];
        end

        inflight_slot #(
            .REG_ADDR_W (REG_ADDR_W)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid),
            .in_wreg    (in_wreg),
            .in_dst     (in_dst),
            .in_is_load (in_is_load),
            .rs         (id_rs),
            .rt         (id_rt),
            .use_rs     (id_use_rs),
            .use_rt     (id_use_rt),
            .valid      (s_valid[k]),
            .wreg       (s_wreg[k]),
            .dst        (s_dst[k]),
            .is_load    (s_is_load[k]),
            .match_rs   (match_rs[k]),
            .match_rt   (match_rt[k])
        );
    end

    // Forwarding select: the youngest matching producer wins.
    always_comb begin
        fwda = FWD_W'(FWD_SEL_RF);
        fwdb = FWD_W'(FWD_SEL_RF);
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (match_rs[k]) fwda = FWD_W'(k + 1);
            if (match_rt[k]) fwdb = FWD_W'(k + 1);
        end
    end

    // Stall, accept and flush decisions for the ID instruction.
    always_comb begin
        load_use  = (match_rs[0] | match_rt[0]) & s_is_load[0];
        // On the final busy cycle the unit frees up, so a waiting MDU op
        // may issue back-to-back instead of stalling.
        mdu_stall = (mdu_state == BUSY) & id_is_mdu & (mdu_cnt != '0);
        stall     = id_valid & (load_use | mdu_stall);
        accepted  = id_valid & ~stall;
        flush     = id_valid & id_branch_taken & ~stall;
        mdu_busy  = (mdu_state == BUSY);
    end

    // MDU state and countdown registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_state <= IDLE;
            mdu_cnt   <= '0;
        end else begin
            mdu_state <= mdu_state_d;
            mdu_cnt   <= mdu_cnt_d;
        end
    end

    // MDU next state: count down MDU_LAT cycles per accepted operation.
    always_comb begin
        mdu_state_d = mdu_state;
        mdu_cnt_d   = mdu_cnt;
        case (mdu_state)
            IDLE: begin
                if (accepted && id_is_mdu) begin
                    mdu_state_d = BUSY;
                    mdu_cnt_d   = CNT_W'(MDU_LAT - 1);
                end
            end
            BUSY: begin
                if (mdu_cnt == '0) begin
                    if (accepted && id_is_mdu) begin
                        mdu_state_d = BUSY;
                        mdu_cnt_d   = CNT_W'(MDU_LAT - 1);
                    end else begin
                        mdu_state_d = IDLE;
                        mdu_cnt_d   = '0;
                    end
                end else begin
                    mdu_cnt_d = mdu_cnt - CNT_W'(1);
                end
            end
            default: begin
                mdu_state_d = IDLE;
                mdu_cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with default parameters
// (REG_ADDR_W=5, FWD_DEPTH=2, MDU_LAT=4). The driver pushes the
// expected output vector {fwda, fwdb, stall, flush, mdu_busy} for each
// cycle it drives; the monitor pops and compares on the falling edge.
module tb_hazard_unit;

    localparam int W = 7;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_wreg;
    logic [4:0] id_dst;
    logic       id_is_load;
    logic       id_is_mdu;
    logic       id_branch_taken;
    logic [1:0] fwda;
    logic [1:0] fwdb;
    logic       stall;
    logic       flush;
    logic       mdu_busy;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks;
    int           errors;
    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_got;
    string        mon_name;

    hazard_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_wreg         (id_wreg),
        .id_dst          (id_dst),
        .id_is_load      (id_is_load),
        .id_is_mdu       (id_is_mdu),
        .id_branch_taken (id_branch_taken),
        .fwda            (fwda),
        .fwdb            (fwdb),
        .stall           (stall),
        .flush           (flush),
        .mdu_busy        (mdu_busy)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of ID inputs and queue the outputs expected for it.
    task automatic drive(
        input logic       rst, v,
        input logic [4:0] rs, rt,
        input logic       urs, urt, w,
        input logic [4:0] dst,
        input logic       ld, mdu, br,
        input logic [1:0] ea, eb,
        input logic       es, ef, eby,
        input string      name
    );
        rst_n           = rst;
        id_valid        = v;
        id_rs           = rs;
        id_rt           = rt;
        id_use_rs       = urs;
        id_use_rt       = urt;
        id_wreg         = w;
        id_dst          = dst;
        id_is_load      = ld;
        id_is_mdu       = mdu;
        id_branch_taken = br;
        exp_q.push_back({ea, eb, es, ef, eby});
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_got  = {fwda, fwdb, stall, flush, mdu_busy};
            checks++;
            if (mon_got !== mon_exp) begin
                errors++;
                $display("FAIL %s: got fwda=%0d fwdb=%0d stall=%b flush=%b mdu_busy=%b, expected fwda=%0d fwdb=%0d stall=%b flush=%b mdu_busy=%b",
                         mon_name, mon_got[6:5], mon_got[4:3], mon_got[2], mon_got[1], mon_got[0],
                         mon_exp[6:5], mon_exp[4:3], mon_exp[2], mon_exp[1], mon_exp[0]);
            end
        end
    end

    // stimulus
    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_wreg = 1'b0; id_dst = '0; id_is_load = 1'b0; id_is_mdu = 1'b0; id_branch_taken = 1'b0;
        @(posedge clk);
        #1;

        //     rst v  rs rt urs urt w dst ld mdu br   fa fb st fl bz
        drive(0, 1, 3, 0, 1, 0, 1, 3, 0, 0, 1,   0, 0, 0, 1, 0, "reset_outputs");
        // ADD r3 then three readers of r3
        drive(1, 1, 1, 2, 1, 1, 1, 3, 0, 0, 0,   0, 0, 0, 0, 0, "add_r3_issue");
        drive(1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, "fwd_rs_slot1");
        drive(1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, "fwd_rs_slot2");
        drive(1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, "fwd_rs_retired");
        // load to r0 is never a producer
        drive(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0, "write_r0");
        drive(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, "read_r0_no_fwd");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, "bubble_a");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, "bubble_b");
        // LW r4 then a taken branch reading r4
        drive(1, 1, 0, 0, 0, 0, 1, 4, 1, 0, 0,   0, 0, 0, 0, 0, "lw_r4_issue");
        drive(1, 1, 0, 4, 0, 1, 0, 0, 0, 0, 1,   0, 1, 1, 0, 0, "load_use_stall");
        drive(1, 1, 0, 4, 0, 1, 0, 0, 0, 0, 1,   0, 2, 0, 1, 0, "after_stall_fwdb2_flush");
        // two writers of r5: use flags and youngest-wins priority
        drive(1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0,   0, 0, 0, 0, 0, "add_r5_issue");
        drive(1, 1, 5, 5, 0, 1, 1, 5, 0, 0, 0,   0, 1, 0, 0, 0, "use_rs_gated");
        drive(1, 1, 5, 5, 1, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, "lowest_slot_wins");
        drive(1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, "fwd_rs_slot2_r5");
        // MDU op, then a second MDU op waiting in ID
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, "mdu_issue");
        for (int i = 0; i < 3; i++)
            drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, "mdu_busy_stall");
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, "mdu_back_to_back");
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 1, "non_mdu_proceeds");
        drive(1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0,   0, 0, 0, 0, 1, "busy_write_r7");
        drive(1, 1, 7, 0, 1, 0, 1, 8, 0, 0, 0,   1, 0, 0, 0, 1, "busy_fwd_r7");
        // asynchronous reset while busy with both slots holding writers
        drive(0, 1, 8, 7, 1, 1, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, "async_reset_mid_busy");
        drive(1, 1, 8, 7, 1, 1, 1, 9, 1, 0, 0,   0, 0, 0, 0, 0, "after_reset_lw_r9");
        // load-use hazard on an MDU op: stall wins, MDU not started
        drive(1, 1, 9, 0, 1, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0, 0, "load_use_beats_mdu");
        drive(1, 1, 9, 0, 1, 0, 0, 0, 0, 1, 0,   2, 0, 0, 0, 0, "mdu_accepted_after_lu");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, "invalid_mdu_no_stall");
        for (int i = 0; i < 3; i++)
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "mdu_busy_hold");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, "mdu_done");

        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
